// File: rtl/data_memory_bus.sv
// Data memory bus: sized/signed ARM loads and stores over a word RAM,
// with alignment/range faults and a wait-state req/ready handshake.
module data_memory_bus #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD,
  output logic              ready,
  output logic              fault
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFS = $clog2(NB);
  localparam int IW   = $clog2(DEPTH);
  localparam logic       NO_WAIT = (WAIT == 0);
  localparam logic [3:0] WAIT_M1 = 4'((WAIT > 0) ? WAIT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                idle;
  logic [ADDR_W-1:0]   acc_a;
  logic                acc_we;
  logic [1:0]          acc_size;
  logic                acc_sign;
  logic [DATA_W-1:0]   acc_wd;
  logic                acc_bad;
  logic                enter;
  logic                mem_we;
  logic [IW-1:0]       idx;
  logic [OFFS-1:0]     off;
  logic [OFFS+2:0]     shamt;
  logic [DATA_W-1:0]   word;
  logic [DATA_W-1:0]   sh;
  logic [DATA_W-1:0]   ld;
  logic [NB-1:0]       be;
  logic [DATA_W-1:0]   wdat;

  // With no wait states the access completes straight from IDLE,
  // so the live inputs stand in for the not-yet-captured ones.
  always_comb begin
    idle     = (state_q == S_IDLE);
    acc_a    = idle ? A    : a_q;
    acc_we   = idle ? we   : we_q;
    acc_size = idle ? size : size_q;
    acc_sign = idle ? sign : sign_q;
    acc_wd   = idle ? WD   : wd_q;
    idx      = acc_a[OFFS+IW-1:OFFS];
    off      = acc_a[OFFS-1:0];
    shamt    = {off, 3'b000};
  end

  // Reject reserved size, misalignment and out-of-range word index.
  always_comb begin
    acc_bad = 1'b0;
    unique case (acc_size)
      2'b00:   acc_bad = 1'b0;
      2'b01:   acc_bad = acc_a[0];
      2'b10:   acc_bad = |acc_a[1:0];
      default: acc_bad = 1'b1;
    endcase
    if ((acc_a >> (OFFS + IW)) != '0)
      acc_bad = 1'b1;
  end

  // The RAM is touched only on the edge that enters RESP.
  always_comb begin
    enter  = (idle && req && NO_WAIT) ||
             (state_q == S_WAIT && cnt_q == 4'd0);
    mem_we = rst_n && enter && acc_we && !acc_bad;
  end

  // Lane select and sign/zero extension for loads.
  always_comb begin
    word = mem[idx];
    sh   = word >> shamt;
    ld   = '0;
    unique case (acc_size)
      2'b00:
        ld = {{(DATA_W-8){acc_sign & sh[7]}}, sh[7:0]};
      2'b01:
        ld = {{(DATA_W-16){acc_sign & sh[15]}}, sh[15:0]};
      default:
        ld = DATA_W'(sh[31:0]);
    endcase
  end

  // Byte-enable mask and lane-aligned store data.
  always_comb begin
    be   = '0;
    wdat = '0;
    unique case (acc_size)
      2'b00: begin
        be   = NB'(4'h1) << off;
        wdat = DATA_W'(acc_wd[7:0]) << shamt;
      end
      2'b01: begin
        be   = NB'(4'h3) << off;
        wdat = DATA_W'(acc_wd[15:0]) << shamt;
      end
      default: begin
        be   = NB'(4'hF) << off;
        wdat = DATA_W'(acc_wd[31:0]) << shamt;
      end
    endcase
  end

  // Next-state, capture and registered response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    ready_d = (state_q == S_RESP);
    fault_d = (state_q == S_RESP) && acc_bad;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          a_d     = A;
          we_d    = we;
          size_d  = size;
          sign_d  = sign;
          wd_d    = WD;
          cnt_d   = WAIT_M1;
          state_d = NO_WAIT ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0)
          state_d = S_RESP;
        else
          cnt_d = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter && !acc_we && !acc_bad)
      rd_d = ld;
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      wd_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Byte-lane RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i])
          mem[idx][i*8 +: 8] <= wdat[i*8 +: 8];
      end
    end
  end

  assign RD    = rd_q;
  assign ready = ready_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_data_memory_bus.sv
// Directed bench for data_memory_bus with WAIT=2.
// Each scenario task checks its own results inline.
module tb_data_memory_bus;

  localparam int WAIT = 2;
  localparam int LAT  = WAIT + 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic        sign  = 1'b0;
  logic [31:0] A     = '0;
  logic [31:0] WD    = '0;
  logic [31:0] RD;
  logic        ready;
  logic        fault;

  int checks = 0;
  int errors = 0;

  data_memory_bus #(
    .DATA_W(32),
    .ADDR_W(32),
    .DEPTH (64),
    .WAIT  (WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .we   (we),
    .size (size),
    .sign (sign),
    .A    (A),
    .WD   (WD),
    .RD   (RD),
    .ready(ready),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // One request; returns edges from sample to ready (-1 on timeout).
  task automatic access(input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] d,
                        output int lat, output logic flt);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign = sg; A = a; WD = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; A = ~a; WD = ~d; sign = ~sg;
    lat = -1;
    flt = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = i;
        flt = fault;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (RD !== 32'h0) begin
      errors++; $display("FAIL reset_rd: got %h want 0", RD);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL reset_fault: got %b want 0", fault);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    int lat;
    logic flt;
    access(1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_00FF, lat, flt);
    checks++;
    if (lat !== LAT || flt !== 1'b0) begin
      errors++; $display("FAIL st_word: lat %0d flt %b want %0d 0", lat, flt, LAT);
    end
    access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, flt);
    checks++;
    if (lat !== LAT || flt !== 1'b0) begin
      errors++; $display("FAIL ld_word_lat: lat %0d flt %b want %0d 0", lat, flt, LAT);
    end
    checks++;
    if (RD !== 32'h0000_00FF) begin
      errors++; $display("FAIL ld_word: got %h want 000000ff", RD);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL ready_width: got %b want 0", ready);
    end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic flt;
    access(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344, lat, flt);
    access(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AA, lat, flt);
    access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'h1122_AA44) begin
      errors++; $display("FAIL byte_merge: got %h want 1122aa44", RD);
    end
    access(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'hFFFF_FFAA) begin
      errors++; $display("FAIL ldsb: got %h want ffffffaa", RD);
    end
    access(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'h0000_00AA) begin
      errors++; $display("FAIL ldrb: got %h want 000000aa", RD);
    end
    access(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'h0000_0011) begin
      errors++; $display("FAIL ldrb_top: got %h want 00000011", RD);
    end
  endtask

  task automatic test_half();
    int lat;
    logic flt;
    access(1'b1, 2'b10, 1'b0, 32'h8, 32'h0, lat, flt);
    access(1'b1, 2'b01, 1'b0, 32'hA, 32'h1234_BEEF, lat, flt);
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'hBEEF_0000) begin
      errors++; $display("FAIL half_merge: got %h want beef0000", RD);
    end
    access(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'h0000_BEEF) begin
      errors++; $display("FAIL ldrh: got %h want 0000beef", RD);
    end
    access(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'hFFFF_BEEF) begin
      errors++; $display("FAIL ldrsh: got %h want ffffbeef", RD);
    end
  endtask

  task automatic test_faults();
    int lat;
    logic flt;
    access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat, flt);
    checks++;
    if (lat !== LAT || flt !== 1'b1) begin
      errors++; $display("FAIL flt_word: lat %0d flt %b want %0d 1", lat, flt, LAT);
    end
    access(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, lat, flt);
    checks++;
    if (lat !== LAT || flt !== 1'b1) begin
      errors++; $display("FAIL flt_half: lat %0d flt %b want %0d 1", lat, flt, LAT);
    end
    access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, flt);
    checks++;
    if (lat !== LAT || flt !== 1'b1) begin
      errors++; $display("FAIL flt_size: lat %0d flt %b want %0d 1", lat, flt, LAT);
    end
    checks++;
    if (RD !== 32'hFFFF_BEEF) begin
      errors++; $display("FAIL flt_rd_hold: got %h want ffffbeef", RD);
    end
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678, lat, flt);
    checks++;
    if (lat !== LAT || flt !== 1'b1) begin
      errors++; $display("FAIL flt_range: lat %0d flt %b want %0d 1", lat, flt, LAT);
    end
    access(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000_5555, lat, flt);
    access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'h0000_00FF || flt !== 1'b0) begin
      errors++; $display("FAIL flt_no_wr0: got %h f%b want 000000ff", RD, flt);
    end
    access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'h1122_AA44) begin
      errors++; $display("FAIL flt_no_wr4: got %h want 1122aa44", RD);
    end
    access(1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFE_F00D, lat, flt);
    access(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'hCAFE_F00D || flt !== 1'b0) begin
      errors++; $display("FAIL top_word: got %h f%b want cafef00d", RD, flt);
    end
  endtask

  task automatic test_ignore_req();
    int n = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sign = 1'b0; A = 32'h4;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; A = 32'h4; WD = 32'h0;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    if (ready) n++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL ignore_pulses: got %0d want 1", n);
    end
    checks++;
    if (RD !== 32'h1122_AA44) begin
      errors++; $display("FAIL ignore_rd: got %h want 1122aa44", RD);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int e1 = -1;
    int e2 = -1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sign = 1'b0; A = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        n++;
        if (e1 < 0) e1 = i; else e2 = i;
      end
    end
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (n !== 2 || e1 !== 4 || e2 !== 8) begin
      errors++; $display("FAIL b2b: n %0d at %0d,%0d want 2 at 4,8", n, e1, e2);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    int n = 0;
    logic flt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; A = 32'h8; WD = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (RD !== 32'h0 || ready !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL mid_rst: rd %h r%b f%b want 0", RD, ready, fault);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL mid_rst_ready: got %0d pulses want 0", n);
    end
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, flt);
    checks++;
    if (RD !== 32'hBEEF_0000 || lat !== LAT) begin
      errors++; $display("FAIL mid_rst_ram: got %h lat %0d want beef0000", RD, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_half();
    test_faults();
    test_ignore_req();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
